// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline-stage register: DEPTH slices of {valid, ctrl, data, pc} with stall, flush and flush_all.
// Optional PIPE_STAGE_PERF_EN adds the stall_cnt / bubble_cnt performance counters.
module pipe_stage_reg #(
  parameter int                CTRL_W      = 16,
  parameter int                DATA_W      = 96,
  parameter int                PC_W        = 32,
  parameter int                DEPTH       = 1,
  parameter logic [CTRL_W-1:0] BUBBLE_CTRL = '0,
  localparam int               OCC_W       = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              flush_all,
  input  logic              in_valid,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic [PC_W-1:0]   in_pc,
`ifdef PIPE_STAGE_PERF_EN
  output logic [31:0]       stall_cnt,
  output logic [31:0]       bubble_cnt,
`endif
  output logic              out_valid,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [PC_W-1:0]   out_pc,
  output logic [OCC_W-1:0]  occupancy
);

  // Handshake: valid-only, no ready. An entry is accepted into slice 0 whenever
  // stall, flush and flush_all are all low; in_valid=0 then loads a bubble.

  if (DEPTH < 1 || DEPTH > 4) begin : g_depth_check
    $error("pipe_stage_reg: DEPTH must be in 1..4");
  end

  logic [DEPTH-1:0] v_q;
  logic [CTRL_W-1:0] ctrl_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [PC_W-1:0]   pc_q   [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        v_q[k]    <= 1'b0;
        ctrl_q[k] <= BUBBLE_CTRL;
        data_q[k] <= '0;
        pc_q[k]   <= '0;
      end
    end else if (flush_all) begin
      // Data is left alone so forwarding paths keep stable operands.
      for (int k = 0; k < DEPTH; k++) begin
        v_q[k]    <= 1'b0;
        ctrl_q[k] <= BUBBLE_CTRL;
        pc_q[k]   <= '0;
      end
    end else begin
      if (flush) begin
        v_q[0]    <= 1'b0;
        ctrl_q[0] <= BUBBLE_CTRL;
        data_q[0] <= in_data;
        pc_q[0]   <= '0;
      end else if (!stall) begin
        v_q[0]    <= in_valid;
        ctrl_q[0] <= in_valid ? in_ctrl : BUBBLE_CTRL;
        data_q[0] <= in_data;
        pc_q[0]   <= in_pc;
      end
      if (!stall) begin
        for (int k = 1; k < DEPTH; k++) begin
          v_q[k]    <= v_q[k-1];
          ctrl_q[k] <= ctrl_q[k-1];
          data_q[k] <= data_q[k-1];
          pc_q[k]   <= pc_q[k-1];
        end
      end
    end
  end

  assign out_valid = v_q[DEPTH-1];
  assign out_ctrl  = ctrl_q[DEPTH-1];
  assign out_data  = data_q[DEPTH-1];
  assign out_pc    = pc_q[DEPTH-1];

  always_comb begin
    occupancy = '0;
    for (int k = 0; k < DEPTH; k++) begin
      occupancy = occupancy + OCC_W'(v_q[k]);
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  logic slot0_bubble;
  // Slice 0 loads a bubble on any flush, or on an advance with in_valid low.
  assign slot0_bubble = flush_all || flush || (!stall && !in_valid);

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (stall && !flush && !flush_all) stall_cnt <= stall_cnt + 32'd1;
      if (slot0_bubble) bubble_cnt <= bubble_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: four instances (DEPTH 1..4) share one input stream and are checked
// every cycle against a per-depth slice model, plus directed scenarios with fixed expected values.
module tb_pipe_stage_reg;

  localparam logic [15:0] BUB = 16'h0002;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, stall, flush, flush_all, in_valid;
  logic [15:0] in_ctrl;
  logic [95:0] in_data;
  logic [31:0] in_pc;

  logic        ov [1:4];
  logic [15:0] oc [1:4];
  logic [95:0] od [1:4];
  logic [31:0] op [1:4];
  logic [2:0]  oo [1:4];
`ifdef PIPE_STAGE_PERF_EN
  logic [31:0] sc [1:4];
  logic [31:0] bc [1:4];
`endif

  for (genvar g = 1; g <= 4; g++) begin : g_dut
    logic [$clog2(g+1)-1:0] occ;
    pipe_stage_reg #(
      .CTRL_W(16), .DATA_W(96), .PC_W(32), .DEPTH(g), .BUBBLE_CTRL(BUB)
    ) u_dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush), .flush_all(flush_all),
      .in_valid(in_valid), .in_ctrl(in_ctrl), .in_data(in_data), .in_pc(in_pc),
`ifdef PIPE_STAGE_PERF_EN
      .stall_cnt(sc[g]), .bubble_cnt(bc[g]),
`endif
      .out_valid(ov[g]), .out_ctrl(oc[g]), .out_data(od[g]), .out_pc(op[g]),
      .occupancy(occ)
    );
    assign oo[g] = 3'(occ);
  end

  // reference model: one entry record per slice position, index 0 = youngest
  bit          mv [1:4][0:3];
  logic [15:0] mc [1:4][0:3];
  logic [95:0] md [1:4][0:3];
  logic [31:0] mp [1:4][0:3];
  logic [31:0] m_stall_cnt, m_bubble_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic model_step();
    for (int d = 1; d <= 4; d++) begin
      if (rst) begin
        for (int i = 0; i < d; i++) begin
          mv[d][i] = 0; mc[d][i] = BUB; md[d][i] = '0; mp[d][i] = '0;
        end
      end else if (flush_all) begin
        for (int i = 0; i < d; i++) begin
          mv[d][i] = 0; mc[d][i] = BUB; mp[d][i] = '0;
        end
      end else begin
        if (!stall) begin
          for (int i = d - 1; i >= 1; i--) begin
            mv[d][i] = mv[d][i-1]; mc[d][i] = mc[d][i-1];
            md[d][i] = md[d][i-1]; mp[d][i] = mp[d][i-1];
          end
        end
        if (flush) begin
          mv[d][0] = 0; mc[d][0] = BUB; md[d][0] = in_data; mp[d][0] = '0;
        end else if (!stall) begin
          mv[d][0] = in_valid; mc[d][0] = in_valid ? in_ctrl : BUB;
          md[d][0] = in_data;  mp[d][0] = in_pc;
        end
      end
    end
    if (rst) begin
      m_stall_cnt = 0; m_bubble_cnt = 0;
    end else begin
      if (stall && !flush && !flush_all) m_stall_cnt++;
      if (flush_all || flush || (!stall && !in_valid)) m_bubble_cnt++;
    end
  endtask

  task automatic check_model();
    for (int d = 1; d <= 4; d++) begin
      int cnt = 0;
      for (int i = 0; i < d; i++) cnt += int'(mv[d][i]);
      check($sformatf("d%0d_valid", d), 128'(ov[d]), 128'(mv[d][d-1]));
      check($sformatf("d%0d_ctrl", d),  128'(oc[d]), 128'(mc[d][d-1]));
      check($sformatf("d%0d_data", d),  128'(od[d]), 128'(md[d][d-1]));
      check($sformatf("d%0d_pc", d),    128'(op[d]), 128'(mp[d][d-1]));
      check($sformatf("d%0d_occ", d),   128'(oo[d]), 128'(cnt));
`ifdef PIPE_STAGE_PERF_EN
      check($sformatf("d%0d_stall_cnt", d),  128'(sc[d]), 128'(m_stall_cnt));
      check($sformatf("d%0d_bubble_cnt", d), 128'(bc[d]), 128'(m_bubble_cnt));
`endif
    end
  endtask

  // driver: apply inputs for one cycle, step the model at the edge, check 1 time unit later
  task automatic cycle(input logic r, input logic st, input logic fl, input logic fa,
                       input logic iv, input logic [15:0] c, input logic [95:0] dt,
                       input logic [31:0] p);
    rst = r; stall = st; flush = fl; flush_all = fa;
    in_valid = iv; in_ctrl = c; in_data = dt; in_pc = p;
    @(posedge clk);
    model_step();
    #1;
    check_model();
  endtask

  task automatic send(input logic [15:0] c, input logic [31:0] p);
    cycle(0, 0, 0, 0, 1, c, {$urandom, $urandom, $urandom}, p);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int d = 1; d <= 4; d++)
      for (int i = 0; i < 4; i++) begin
        mv[d][i] = 0; mc[d][i] = BUB; md[d][i] = '0; mp[d][i] = '0;
      end
    m_stall_cnt = 0; m_bubble_cnt = 0;

    // reset held two cycles
    cycle(1, 0, 0, 0, 1, 16'hFFFF, 96'h5, 32'h44);
    cycle(1, 0, 0, 0, 1, 16'hFFFF, 96'h5, 32'h44);
    check("rst_valid", 128'(ov[2]), 128'(0));
    check("rst_ctrl",  128'(oc[2]), 128'(16'h0002));
    check("rst_pc",    128'(op[2]), 128'(0));
    check("rst_occ",   128'(oo[2]), 128'(0));

    // streaming through DEPTH=2
    send(16'h0011, 32'h100);
    send(16'h0022, 32'h104);
    check("lat_pc0",  128'(op[2]), 128'(32'h100));
    check("lat_ctrl", 128'(oc[2]), 128'(16'h0011));
    send(16'h0033, 32'h108);
    check("lat_pc1",  128'(op[2]), 128'(32'h104));
    check("full_occ", 128'(oo[2]), 128'(2));

    // stall three cycles, outputs frozen
    for (int i = 0; i < 3; i++) begin
      cycle(0, 1, 0, 0, 1, 16'h0044, 96'h7, 32'h10C);
      check("stall_pc", 128'(op[2]), 128'(32'h104));
    end
    send(16'h0044, 32'h10C);
    check("release_pc", 128'(op[2]), 128'(32'h108));

    // flush + stall on DEPTH=1: bubble with data passed through
    cycle(0, 1, 1, 0, 1, 16'h0055, 96'hABC, 32'h200);
    check("fl_valid", 128'(ov[1]), 128'(0));
    check("fl_ctrl",  128'(oc[1]), 128'(BUB));
    check("fl_pc",    128'(op[1]), 128'(0));
    check("fl_data",  128'(od[1]), 128'(96'hABC));

    // fill DEPTH=3 then flush_all while stalled
    send(16'h0101, 32'h300);
    send(16'h0102, 32'h304);
    send(16'h0103, 32'h308);
    check("fill_occ3", 128'(oo[3]), 128'(3));
    cycle(0, 1, 0, 1, 1, 16'h0104, 96'h9, 32'h30C);
    check("fa_occ3",  128'(oo[3]), 128'(0));
    check("fa_ctrl3", 128'(oc[3]), 128'(BUB));
    for (int i = 0; i < 2; i++) begin
      cycle(0, 0, 0, 0, 0, 16'h0105, 96'h9, 32'h310);
      check("fa_drain_ctrl3", 128'(oc[3]), 128'(BUB));
    end

    // mid-stream reset
    send(16'h0201, 32'h400);
    send(16'h0202, 32'h404);
    send(16'h0203, 32'h408);
    cycle(1, 0, 0, 0, 1, 16'h0204, 96'h1, 32'h40C);
    check("mrst_occ3",  128'(oo[3]), 128'(0));
    check("mrst_occ4",  128'(oo[4]), 128'(0));
    check("mrst_ctrl3", 128'(oc[3]), 128'(BUB));

`ifdef PIPE_STAGE_PERF_EN
    for (int i = 0; i < 5; i++) cycle(0, 1, 0, 0, 1, 16'h0301, 96'h2, 32'h500);
    for (int i = 0; i < 2; i++) cycle(0, 0, 1, 0, 1, 16'h0302, 96'h3, 32'h504);
    cycle(0, 0, 0, 0, 0, 16'h0303, 96'h4, 32'h508);
    check("perf_stall",  128'(sc[2]), 128'(5));
    check("perf_bubble", 128'(bc[2]), 128'(3));
    cycle(1, 0, 0, 0, 1, 16'h0304, 96'h5, 32'h50C);
    check("perf_rst_stall",  128'(sc[2]), 128'(0));
    check("perf_rst_bubble", 128'(bc[2]), 128'(0));
`endif

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 99) < 2,  $urandom_range(0, 99) < 20,
            $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 5,
            $urandom_range(0, 99) < 75, 16'($urandom),
            {$urandom, $urandom, $urandom}, $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
